// File: rtl/dfswt_pkg.sv
// Shared types and constants for the DFSWT frame controller.
// State encoding, default sizes and saturating-count helper.
package dfswt_pkg;

  localparam int DEF_FRAME = 64;
  localparam int DEF_FBITS = 6;
  localparam int DEF_NBINS = 4;
  localparam int MAG_W     = 32;
  localparam int IDX_W     = 3;

  localparam logic [7:0] OVR_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_SETTLE,
    ST_SCAN,
    ST_HOLD
  } state_t;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == OVR_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dfswt_peak_scan.sv
// Running unsigned maximum over a stream of bins.
// Ties keep the earlier (lower) index.
module dfswt_peak_scan
  import dfswt_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [MAG_W-1:0] bin,
  input  logic [IDX_W-1:0] index,
  output logic [MAG_W-1:0] max,
  output logic [IDX_W-1:0] argmax
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max    <= '0;
      argmax <= '0;
    end else if (enable) begin
      if (start || (bin > max)) begin
        max    <= bin;
        argmax <= index;
      end
    end
  end

endmodule

// File: rtl/dfswt_frame_ctrl.sv
// Frame sequencer for a sliding-window bank: clear, accumulate,
// settle, scan for the peak bin, then hold the result for handoff.
module dfswt_frame_ctrl
  import dfswt_pkg::*;
#(
  parameter int FRAME = DEF_FRAME,
  parameter int FBITS = DEF_FBITS,
  parameter int NBINS = DEF_NBINS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [15:0]            datain,
  input  logic [MAG_W*NBINS-1:0] magnitude,
  output logic                   stage_clear,
  output logic                   stage_enable,
  output logic [15:0]            stage_data,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [2:0]             peak_bin,
  output logic [31:0]            peak_mag,
  output logic [7:0]             overrun
);

  localparam logic [FBITS-1:0] LAST_SMP =
    FBITS'(FRAME - 1);
  localparam logic [IDX_W-1:0] LAST_BIN =
    IDX_W'(NBINS - 1);

  state_t state;
  state_t state_n;

  logic [FBITS-1:0] frame_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic             accept;
  logic             drop;
  logic             handoff;
  logic             scan_en;
  logic             scan_start;
  logic [MAG_W-1:0] bin_val;
  logic [MAG_W-1:0] run_max;
  logic [IDX_W-1:0] run_arg;
  logic [MAG_W-1:0] hold_mag;
  logic [IDX_W-1:0] hold_bin;
  logic             en_q;
  logic [15:0]      data_q;
  logic [7:0]       ovr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    handoff = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        state_n = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (sample_valid) begin
          accept = 1'b1;
          if (frame_cnt == LAST_SMP) begin
            state_n = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        state_n = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_idx == LAST_BIN) begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          handoff = 1'b1;
          state_n = ST_CLEAR;
        end
      end
      default: begin
        state_n = ST_CLEAR;
      end
    endcase
  end

  assign drop       = sample_valid && (state != ST_ACCUM);
  assign scan_en    = (state == ST_SCAN);
  assign scan_start = (scan_idx == '0);

  always_comb begin
    bin_val = '0;
    for (int k = 0; k < NBINS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        bin_val = magnitude[k*MAG_W +: MAG_W];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      scan_idx  <= '0;
      en_q      <= 1'b0;
      data_q    <= '0;
      ovr_q     <= '0;
      hold_mag  <= '0;
      hold_bin  <= '0;
    end else begin
      en_q <= accept;
      if (accept) begin
        data_q    <= datain;
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (state == ST_CLEAR) begin
        frame_cnt <= '0;
      end
      if (scan_en && (scan_idx != LAST_BIN)) begin
        scan_idx <= scan_idx + 1'b1;
      end else begin
        scan_idx <= '0;
      end
      if (drop) begin
        ovr_q <= sat_inc(ovr_q);
      end
      // Latch the delivered result so the next scan can't disturb it.
      if (handoff) begin
        hold_mag <= run_max;
        hold_bin <= run_arg;
      end
    end
  end

  dfswt_peak_scan u_scan (
    .clock  (clock),
    .reset  (reset),
    .enable (scan_en),
    .start  (scan_start),
    .bin    (bin_val),
    .index  (scan_idx),
    .max    (run_max),
    .argmax (run_arg)
  );

  assign stage_clear  = (state == ST_CLEAR);
  assign stage_enable = en_q;
  assign stage_data   = data_q;
  assign result_valid = (state == ST_HOLD);
  assign peak_mag     = result_valid ? run_max : hold_mag;
  assign peak_bin     = result_valid ? run_arg : hold_bin;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_dfswt_frame_ctrl.sv
// Directed bench for dfswt_frame_ctrl with FRAME=8, NBINS=4.
// Expected values are hand-derived from the frame timing.
module tb_dfswt_frame_ctrl;

  localparam int FRAME = 8;
  localparam int FBITS = 3;
  localparam int NBINS = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         sample_valid = 1'b0;
  logic [15:0]  datain = '0;
  logic [127:0] magnitude = '0;
  logic         result_ready = 1'b0;
  logic         stage_clear;
  logic         stage_enable;
  logic [15:0]  stage_data;
  logic         result_valid;
  logic [2:0]   peak_bin;
  logic [31:0]  peak_mag;
  logic [7:0]   overrun;

  int checks = 0;
  int passed = 0;
  int pulses;
  int n;

  always #5 clock = ~clock;

  dfswt_frame_ctrl #(
    .FRAME (FRAME),
    .FBITS (FBITS),
    .NBINS (NBINS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .datain       (datain),
    .magnitude    (magnitude),
    .stage_clear  (stage_clear),
    .stage_enable (stage_enable),
    .stage_data   (stage_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .overrun      (overrun)
  );

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    chk("clr_en_excl", 64'(stage_clear & stage_enable), 64'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_clr"}, 64'(stage_clear), 64'd1);
    chk({tag, "_en"}, 64'(stage_enable), 64'd0);
    chk({tag, "_data"}, 64'(stage_data), 64'd0);
    chk({tag, "_rv"}, 64'(result_valid), 64'd0);
    chk({tag, "_pbin"}, 64'(peak_bin), 64'd0);
    chk({tag, "_pmag"}, 64'(peak_mag), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
  endtask

  initial begin
    magnitude = {32'd9, 32'd3, 32'd9, 32'd5};
    #2;
    chk_reset_vals("rst");
    step();
    step();
    reset = 1'b0;
    chk("clear_pre", 64'(stage_clear), 64'd1);
    step();
    chk("clear_done", 64'(stage_clear), 64'd0);

    // Frame 1: 8 back-to-back samples.
    for (int i = 0; i < 8; i++) begin
      datain = 16'h0100 + 16'(i);
      sample_valid = 1'b1;
      step();
      chk("f1_en", 64'(stage_enable), 64'd1);
      chk("f1_data", 64'(stage_data), 64'(16'h0100 + 16'(i)));
    end
    sample_valid = 1'b0;
    chk("f1_ovr", 64'(overrun), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("f1_rv_lo", 64'(result_valid), 64'd0);
    end
    step();
    chk("f1_rv", 64'(result_valid), 64'd1);
    chk("f1_pbin", 64'(peak_bin), 64'd1);
    chk("f1_pmag", 64'(peak_mag), 64'd9);

    // Drops while held in HOLD.
    sample_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 9) chk("ovr_10", 64'(overrun), 64'd10);
    end
    chk("ovr_sat", 64'(overrun), 64'd255);
    chk("hold_rv", 64'(result_valid), 64'd1);
    chk("hold_pbin", 64'(peak_bin), 64'd1);
    chk("hold_pmag", 64'(peak_mag), 64'd9);

    sample_valid = 1'b0;
    result_ready = 1'b1;
    magnitude = {32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF};
    step();
    chk("ho1_rv", 64'(result_valid), 64'd0);
    chk("ho1_clr", 64'(stage_clear), 64'd1);
    chk("ho1_pbin", 64'(peak_bin), 64'd1);
    chk("ho1_pmag", 64'(peak_mag), 64'd9);
    step();
    chk("f2_accum", 64'(stage_clear), 64'd0);

    // Frame 2: one sample every third cycle, ready held high.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      datain = 16'hF000 | 16'(i);
      sample_valid = 1'b1;
      step();
      chk("f2_en", 64'(stage_enable), 64'd1);
      chk("f2_data", 64'(stage_data), 64'(16'hF000 | 16'(i)));
      if (stage_enable) pulses++;
      sample_valid = 1'b0;
      for (int g = 0; g < 2; g++) begin
        step();
        chk("f2_gap_en", 64'(stage_enable), 64'd0);
        if (stage_enable) pulses++;
      end
    end
    chk("f2_pulses", 64'(pulses), 64'd8);
    n = 0;
    while (!result_valid && n < 20) begin
      step();
      n++;
    end
    chk("f2_wait", 64'(n), 64'd3);
    chk("f2_rv", 64'(result_valid), 64'd1);
    chk("f2_pbin", 64'(peak_bin), 64'd0);
    chk("f2_pmag", 64'(peak_mag), 64'hFFFF_FFFF);
    step();
    chk("f2_rv_1cyc", 64'(result_valid), 64'd0);
    chk("f2_clr", 64'(stage_clear), 64'd1);
    chk("f2_keep_bin", 64'(peak_bin), 64'd0);
    chk("f2_keep_mag", 64'(peak_mag), 64'hFFFF_FFFF);
    chk("f2_ovr", 64'(overrun), 64'd255);
    step();
    result_ready = 1'b0;

    // Frame 3: reset after the 5th sample.
    magnitude = {32'd4, 32'd3, 32'd2, 32'd1};
    for (int i = 0; i < 5; i++) begin
      datain = 16'h0A00 + 16'(i);
      sample_valid = 1'b1;
      step();
      chk("f3_en", 64'(stage_enable), 64'd1);
    end
    sample_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("arst");
    #2;
    reset = 1'b0;
    step();
    chk("f4_clear_done", 64'(stage_clear), 64'd0);

    // Frame 4 must need a full 8 new samples.
    for (int i = 0; i < 8; i++) begin
      datain = 16'h0B00 + 16'(i);
      sample_valid = 1'b1;
      step();
      chk("f4_en", 64'(stage_enable), 64'd1);
      chk("f4_data", 64'(stage_data), 64'(16'h0B00 + 16'(i)));
      chk("f4_ovr", 64'(overrun), 64'd0);
    end
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("f4_rv_lo", 64'(result_valid), 64'd0);
    end
    step();
    chk("f4_rv", 64'(result_valid), 64'd1);
    chk("f4_pbin", 64'(peak_bin), 64'd3);
    chk("f4_pmag", 64'(peak_mag), 64'd4);
    result_ready = 1'b1;
    step();
    chk("f4_rv_off", 64'(result_valid), 64'd0);
    chk("f4_clr", 64'(stage_clear), 64'd1);
    chk("f4_keep_bin", 64'(peak_bin), 64'd3);
    result_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dfswt_frame_ctrl.md
DFSWT_FRAME_CTRL -- requirements
Module: dfswt_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME, 64, accepted samples per analysis frame (power of two, 4..1024).
REQ-002 SHALL have parameter FBITS, 6, frame counter width, equal to log2(FRAME).
REQ-003 SHALL have parameter NBINS, 4, number of stages in the bank (2..8).
REQ-004 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port sample_valid  input  1  datain carries a new sample this cycle.
REQ-007 SHALL have port datain  input  16  signed sample.
REQ-008 SHALL have port magnitude  input  32*NBINS  packed bank magnitudes, bin k at bits [32k+31:32k], unsigned.
REQ-009 SHALL have port stage_clear  output  1  clear request to the bank.
REQ-010 SHALL have port stage_enable  output  1  bank accumulate strobe.
REQ-011 SHALL have port stage_data  output  16  registered sample to the bank.
REQ-012 SHALL have port result_valid  output  1  peak result is held and valid.
REQ-013 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port peak_bin  output  3  index of the largest magnitude.
REQ-015 SHALL have port peak_mag  output  32  value of the largest magnitude.
REQ-016 SHALL have port overrun  output  8  saturating count of dropped samples.

Function
REQ-017 SHALL implement the states CLEAR, ACCUM, SETTLE, SCAN and HOLD, with CLEAR as the state after reset.
REQ-018 CLEAR SHALL drive stage_clear=1 and stage_enable=0 for exactly one cycle, zero the frame counter, then go to ACCUM.
REQ-019 ACCUM: each cycle with sample_valid=1 SHALL register datain to stage_data, pulse stage_enable the next cycle (one-cycle latency), and increment the frame counter.
REQ-020 On the accepted sample that brings the count to FRAME (counter wraps to 0), the state SHALL move to SETTLE.
REQ-021 SETTLE SHALL last one cycle, during which the final stage_enable pulse is issued; the state then moves to SCAN.
REQ-022 SCAN SHALL examine one bin per cycle, index 0..NBINS-1, taking NBINS cycles.
REQ-023 SCAN SHALL replace the running maximum only when a bin is strictly greater, so ties resolve to the lowest index.
REQ-024 The running maximum SHALL be initialised from bin 0; the comparison SHALL be unsigned 32-bit.
REQ-025 After the last bin, HOLD SHALL assert result_valid with peak_bin and peak_mag stable until a cycle with result_ready=1.
REQ-026 In that handoff cycle the state SHALL move to CLEAR and result_valid SHALL fall the next cycle.
REQ-027 result_ready=1 on the cycle result_valid first rises SHALL complete the handoff in that same cycle.
REQ-028 A sample_valid in CLEAR, SETTLE, SCAN or HOLD SHALL be dropped, and overrun SHALL increment, saturating at 255.
REQ-029 stage_enable SHALL be asserted only for samples accepted in ACCUM.
REQ-030 stage_clear and stage_enable SHALL never be asserted in the same cycle.
REQ-031 peak_bin and peak_mag SHALL retain the last delivered result outside HOLD.

Reset
REQ-032 On reset assertion, independent of clock, the outputs SHALL take these values: stage_clear=1, stage_enable=0, stage_data=0, result_valid=0, peak_bin=0, peak_mag=0, overrun=0; the state SHALL be CLEAR and the counters SHALL be zero.
REQ-033 Reset asserted mid-frame or in HOLD SHALL discard the partial frame and the pending result, with no result_valid pulse.
REQ-034 After reset deasserts, the first clock edge SHALL execute CLEAR.

Structure
REQ-035 The state encoding, the default FRAME/NBINS constants and the magnitude slice width (32) SHALL live in a shared package dfswt_pkg.
REQ-036 The compare-and-hold maximum logic SHALL be the sub-module dfswt_peak_scan (inputs: start, bin value, index; outputs: max, argmax).

Verification
REQ-037 FRAME=8, NBINS=4, 8 consecutive valid samples, magnitudes {5,9,3,9} -> SETTLE and 4 SCAN cycles, then result_valid with peak_bin=1, peak_mag=9 (tie keeps bin 1).
REQ-038 result_ready held 1 -> result_valid high exactly one cycle; stage_clear pulses on the following cycle.
REQ-039 300 sample_valid pulses while held in HOLD with result_ready=0 -> overrun saturates at 255; peak outputs unchanged.
REQ-040 Reset asserted after the 5th sample of a frame -> outputs take their reset values asynchronously; the next frame needs a full 8 new samples.
REQ-041 Gapped sample_valid (1 in 3 cycles) -> exactly 8 stage_enable pulses per frame, each with stage_data equal to the sample accepted on the prior cycle.
REQ-042 Magnitudes {0xFFFFFFFF,0,0,0x80000000} -> peak_bin=0 (confirms the comparison is unsigned).
